// File: rtl/spi_pkg.sv
// Purpose : shared types and constants for the SPI transfer sequencer.
// Contents: FSM state encoding and the fill word that is shifted out when the TX FIFO is not used.
// Users   : spi_xfer_ctrl and its testbench.
package spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_STORE,
        S_DONE
    } spi_state_e;

    // Wide enough for any shifter width in use. The user slices it down to DATA_WIDTH.
    localparam int unsigned SPI_MAX_WIDTH = 64;
    localparam logic [SPI_MAX_WIDTH-1:0] SPI_DUMMY_WORD = '1;

endpackage

// File: rtl/spi_xfer_ctrl.sv
// Purpose : runs a software-programmed SPI transfer one word at a time: TX FIFO pop -> shifter -> RX FIFO push.
// Ports   : start_i/len_i/tx_en_i/rx_en_i/abort_i control; busy_o/done_o/aborted_o/words_o status;
//           tx_* pop handshake, rx_* push handshake, sh_* shifter interface, FIFO levels/watermarks -> irq_*_o.
// Flow    : stalls in FETCH while the TX FIFO is empty and in STORE while the RX FIFO is full; abort wins in any busy state.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned LOG_BUFFER_DEPTH = 3,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic [CNT_WIDTH-1:0]        len_i,
    input  logic                        tx_en_i,
    input  logic                        rx_en_i,
    input  logic                        abort_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        aborted_o,
    output logic [CNT_WIDTH-1:0]        words_o,
    output logic                        fifo_clr_o,
    input  logic                        tx_valid_i,
    input  logic [DATA_WIDTH-1:0]       tx_data_i,
    output logic                        tx_ready_o,
    output logic                        rx_valid_o,
    output logic [DATA_WIDTH-1:0]       rx_data_o,
    input  logic                        rx_ready_i,
    input  logic [LOG_BUFFER_DEPTH:0]   tx_elements_i,
    input  logic [LOG_BUFFER_DEPTH:0]   rx_elements_i,
    input  logic [LOG_BUFFER_DEPTH:0]   tx_wm_i,
    input  logic [LOG_BUFFER_DEPTH:0]   rx_wm_i,
    output logic                        sh_start_o,
    output logic [DATA_WIDTH-1:0]       sh_data_o,
    input  logic                        sh_done_i,
    input  logic [DATA_WIDTH-1:0]       sh_data_i,
    output logic                        irq_tx_o,
    output logic                        irq_rx_o
);

    spi_state_e              state_q;
    logic [CNT_WIDTH-1:0]    remain_q;
    logic [CNT_WIDTH-1:0]    words_q;
    logic                    tx_en_q;
    logic                    rx_en_q;
    logic                    sh_start_q;
    logic [DATA_WIDTH-1:0]   sh_data_q;
    logic [DATA_WIDTH-1:0]   rx_data_q;
    logic                    done_q;
    logic                    aborted_q;
    logic                    fifo_clr_q;
    logic                    irq_tx_q;
    logic                    irq_rx_q;

    // Word-completion arithmetic. It is shared by the SHIFT (no RX) and STORE exits.
    logic [CNT_WIDTH-1:0]    words_d;
    logic [CNT_WIDTH-1:0]    remain_d;
    logic                    last_word;
    logic                    busy;

    assign words_d   = words_q + CNT_WIDTH'(1);
    assign remain_d  = remain_q - CNT_WIDTH'(1);
    assign last_word = (remain_q == CNT_WIDTH'(1));
    assign busy      = (state_q != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            remain_q   <= '0;
            words_q    <= '0;
            tx_en_q    <= 1'b0;
            rx_en_q    <= 1'b0;
            sh_start_q <= 1'b0;
            sh_data_q  <= '0;
            rx_data_q  <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            fifo_clr_q <= 1'b0;
            irq_tx_q   <= 1'b0;
            irq_rx_q   <= 1'b0;
        end else begin
            // These are single-cycle pulses unless a transition below re-asserts them.
            sh_start_q <= 1'b0;
            done_q     <= 1'b0;
            fifo_clr_q <= 1'b0;

            irq_tx_q   <= busy & tx_en_q & (tx_elements_i <= tx_wm_i);
            irq_rx_q   <= (rx_elements_i >= rx_wm_i);

            if (abort_i && busy) begin
                // Abort overrides everything, including an sh_done_i in the same cycle.
                state_q    <= S_IDLE;
                fifo_clr_q <= 1'b1;
                aborted_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            tx_en_q   <= tx_en_i;
                            rx_en_q   <= rx_en_i;
                            remain_q  <= len_i;
                            words_q   <= '0;
                            aborted_q <= 1'b0;
                            if (len_i == '0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_FETCH;
                            end
                        end
                    end
                    S_FETCH: begin
                        if (!tx_en_q) begin
                            sh_data_q  <= SPI_DUMMY_WORD[DATA_WIDTH-1:0];
                            sh_start_q <= 1'b1;
                            state_q    <= S_SHIFT;
                        end else if (tx_valid_i) begin
                            sh_data_q  <= tx_data_i;
                            sh_start_q <= 1'b1;
                            state_q    <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (sh_done_i) begin
                            rx_data_q <= sh_data_i;
                            if (rx_en_q) begin
                                state_q <= S_STORE;
                            end else begin
                                words_q  <= words_d;
                                remain_q <= remain_d;
                                state_q  <= last_word ? S_DONE : S_FETCH;
                                done_q   <= last_word;
                            end
                        end
                    end
                    S_STORE: begin
                        if (rx_ready_i) begin
                            words_q  <= words_d;
                            remain_q <= remain_d;
                            state_q  <= last_word ? S_DONE : S_FETCH;
                            done_q   <= last_word;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy_o     = busy;
    assign done_o     = done_q;
    assign aborted_o  = aborted_q;
    assign words_o    = words_q;
    assign fifo_clr_o = fifo_clr_q;
    assign tx_ready_o = (state_q == S_FETCH) & tx_en_q;
    assign rx_valid_o = (state_q == S_STORE);
    assign rx_data_o  = rx_data_q;
    assign sh_start_o = sh_start_q;
    assign sh_data_o  = sh_data_q;
    assign irq_tx_o   = irq_tx_q;
    assign irq_rx_o   = irq_rx_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Purpose : self-checking bench for spi_xfer_ctrl with TX FIFO, shifter and RX FIFO models.
// Model   : the expected word streams come from queues. The shifter is modelled by a latency countdown.
// Flow    : TX gaps, RX back-pressure and irq levels are randomised or held per scenario.
module tb_spi_xfer_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i, tx_en_i, rx_en_i, abort_i;
    logic [15:0] len_i;
    logic        busy_o, done_o, aborted_o, fifo_clr_o;
    logic [15:0] words_o;
    logic        tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i;
    logic [31:0] tx_data_i, rx_data_o, sh_data_o, sh_data_i;
    logic [3:0]  tx_elements_i, rx_elements_i, tx_wm_i, rx_wm_i;
    logic        sh_start_o, sh_done_i, irq_tx_o, irq_rx_o;

    always #5 clk_i = ~clk_i;

    spi_xfer_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
        .tx_en_i(tx_en_i), .rx_en_i(rx_en_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o), .words_o(words_o),
        .fifo_clr_o(fifo_clr_o), .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i),
        .tx_ready_o(tx_ready_o), .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o),
        .rx_ready_i(rx_ready_i), .tx_elements_i(tx_elements_i), .rx_elements_i(rx_elements_i),
        .tx_wm_i(tx_wm_i), .rx_wm_i(rx_wm_i), .sh_start_o(sh_start_o), .sh_data_o(sh_data_o),
        .sh_done_i(sh_done_i), .sh_data_i(sh_data_i), .irq_tx_o(irq_tx_o), .irq_rx_o(irq_rx_o)
    );

    int n_chk = 0, n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference state
    logic [31:0] tx_q[$];
    logic [31:0] exp_sh[$];
    logic [31:0] exp_rx[$];
    bit   cur_txe, cur_rxe, rnd_v, rx_pend, prev_rx_irq;
    int   lat_v, sh_cnt = -1, tx_hold_cnt, rx_hold_cnt;
    int   cyc = 0, start_cyc, first_start;
    int   n_start, n_done, n_push, n_txrdy;
    int   txrdy_bad, stable_bad, hold_bad, overlap_bad, irq_bad, sh_extra, rx_extra;
    logic [31:0] sh_word, rx_last;

    // One clock of all environment models. Outputs are sampled on the falling edge, and the inputs for the next rising edge are driven here too.
    task automatic tick();
        logic [31:0] w;
        @(negedge clk_i);
        cyc++;
        if (irq_rx_o !== prev_rx_irq) irq_bad++;

        // Shifter: it captures the word on sh_start_o and answers after lat cycles.
        sh_done_i = 1'b0;
        sh_data_i = $urandom;
        if (sh_start_o) begin
            n_start++;
            if (sh_cnt != -1) overlap_bad++;
            if (tx_hold_cnt > 0 || rx_pend) hold_bad++;
            if (first_start < 0) first_start = cyc - start_cyc;
            if (exp_sh.size() == 0) sh_extra++;
            else begin
                w = exp_sh.pop_front();
                check_eq("sh_data", sh_data_o, w);
            end
            sh_word = sh_data_o;
            sh_cnt  = rnd_v ? int'($urandom_range(1, 5)) : lat_v;
        end
        if (sh_cnt > 0) begin
            sh_cnt--;
            if (sh_cnt == 0) begin
                sh_done_i = 1'b1;
                sh_data_i = rnd_v ? $urandom : sh_word;
                if (cur_rxe) exp_rx.push_back(sh_data_i);
                sh_cnt = -1;
            end
        end

        // RX FIFO side
        if (rx_valid_o && rx_hold_cnt > 0) begin
            rx_ready_i = 1'b0;
            rx_hold_cnt--;
        end else begin
            rx_ready_i = rnd_v ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (rx_valid_o) begin
            if (rx_pend && rx_data_o !== rx_last) stable_bad++;
            if (rx_ready_i) begin
                n_push++;
                rx_pend = 1'b0;
                if (exp_rx.size() == 0) rx_extra++;
                else begin
                    w = exp_rx.pop_front();
                    check_eq("rx_data", rx_data_o, w);
                end
            end else begin
                rx_pend = 1'b1;
                rx_last = rx_data_o;
            end
        end

        // TX FIFO side
        if (tx_ready_o) begin
            n_txrdy++;
            if (!cur_txe) txrdy_bad++;
            if (tx_hold_cnt > 0) tx_hold_cnt--;
        end
        tx_valid_i = (tx_hold_cnt == 0) && (tx_q.size() > 0) && (!rnd_v || $urandom_range(0, 2) != 0);
        tx_data_i  = tx_valid_i ? tx_q[0] : $urandom;
        if (tx_valid_i && tx_ready_o) void'(tx_q.pop_front());

        if (done_o) n_done++;

        rx_elements_i = 4'($urandom_range(0, 8));
        rx_wm_i       = 4'($urandom_range(0, 8));
        prev_rx_irq   = (rx_elements_i >= rx_wm_i);
    endtask

    task automatic prep(input int len, input bit txe, input bit rxe, input int txh, input int rxh,
                        input int lat, input bit rnd);
        logic [31:0] w;
        cur_txe = txe; cur_rxe = rxe; tx_hold_cnt = txh; rx_hold_cnt = rxh; lat_v = lat; rnd_v = rnd;
        n_start = 0; n_done = 0; n_push = 0; n_txrdy = 0; first_start = -1;
        txrdy_bad = 0; stable_bad = 0; hold_bad = 0; overlap_bad = 0; irq_bad = 0; sh_extra = 0; rx_extra = 0;
        for (int i = 0; i < len; i++) begin
            w = txe ? $urandom : 32'hFFFF_FFFF;
            if (txe) tx_q.push_back(w);
            exp_sh.push_back(w);
        end
    endtask

    task automatic start_xfer(input int len, input bit txe, input bit rxe);
        start_i = 1'b1; len_i = 16'(len); tx_en_i = txe; rx_en_i = rxe;
        start_cyc = cyc;
        tick();
        // Scramble these after the start so that a design which does not latch them gets caught.
        start_i = 1'b0; len_i = 16'($urandom); tx_en_i = ~txe; rx_en_i = ~rxe;
    endtask

    task automatic wait_done(input int len, input bit rxe, input bit chk_lat);
        int guard = 0;
        while (n_done == 0 && guard < 600) begin
            tick();
            guard++;
        end
        check_eq("xfer_timeout", guard < 600, 1);
        check_eq("busy_at_done", busy_o, 1);
        check_eq("words_at_done", words_o, len);
        tick();
        check_eq("done_width", done_o, 0);
        check_eq("busy_after_done", busy_o, 0);
        tick(); tick();
        check_eq("done_count", n_done, 1);
        check_eq("sh_starts", n_start, len);
        check_eq("sh_left", exp_sh.size() + sh_extra, 0);
        check_eq("rx_pushes", n_push, rxe ? len : 0);
        check_eq("rx_left", exp_rx.size() + rx_extra, 0);
        check_eq("tx_ready_no_tx", txrdy_bad, 0);
        check_eq("rx_stall_stable", stable_bad, 0);
        check_eq("start_in_stall", hold_bad, 0);
        check_eq("sh_overlap", overlap_bad, 0);
        check_eq("irq_rx", irq_bad, 0);
        check_eq("aborted_clear", aborted_o, 0);
        if (chk_lat) check_eq("first_sh_latency", first_start, 2);
    endtask

    task automatic run_xfer(input int len, input bit txe, input bit rxe, input int txh, input int rxh,
                            input int lat, input bit rnd, input bit chk_lat);
        prep(len, txe, rxe, txh, rxh, lat, rnd);
        start_xfer(len, txe, rxe);
        wait_done(len, rxe, chk_lat);
    endtask

    initial begin
        int guard;
        rst_ni = 1'b0; start_i = 0; len_i = 0; tx_en_i = 0; rx_en_i = 0; abort_i = 0;
        tx_valid_i = 0; tx_data_i = 0; rx_ready_i = 0; sh_done_i = 0; sh_data_i = 0;
        tx_elements_i = 4'd4; tx_wm_i = 4'd0; rx_elements_i = 4'd0; rx_wm_i = 4'd1;
        prev_rx_irq = 1'b0; rx_pend = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_status", {busy_o, done_o, aborted_o, fifo_clr_o}, 0);
        check_eq("rst_words", words_o, 0);
        check_eq("rst_handshake", {tx_ready_o, rx_valid_o, sh_start_o}, 0);
        check_eq("rst_sh_data", sh_data_o, 0);
        check_eq("rst_rx_data", rx_data_o, 0);
        check_eq("rst_irq", {irq_tx_o, irq_rx_o}, 0);
        rst_ni = 1'b1;
        tick();

        // Three echoed words with a 4-cycle shifter and the TX data already present.
        run_xfer(3, 1, 1, 0, 0, 4, 0, 1);
        // TX disabled: every word is the dummy word and tx_ready_o never rises.
        run_xfer(2, 0, 1, 0, 0, 3, 0, 0);
        // TX empty at first: FETCH waits with no shifter start.
        run_xfer(2, 1, 1, 10, 0, 2, 0, 0);
        // RX full for 5 cycles: the STORE data must stay stable.
        run_xfer(2, 1, 1, 0, 5, 2, 0, 0);

        // Zero-length start: done follows straight away and neither side moves.
        prep(0, 1, 1, 0, 0, 1, 0);
        start_xfer(0, 1, 1);
        check_eq("len0_done", done_o, 1);
        check_eq("len0_busy", busy_o, 1);
        tick();
        check_eq("len0_done_drop", {done_o, busy_o}, 0);
        tick();
        check_eq("len0_activity", n_start + n_push + n_txrdy, 0);
        check_eq("len0_done_count", n_done, 1);

        // Abort during word 2 of 4, in the same cycle as the shifter's done.
        prep(4, 1, 1, 0, 0, 4, 0);
        start_xfer(4, 1, 1);
        guard = 0;
        while (n_start < 2 && guard < 200) begin tick(); guard++; end
        check_eq("abort_reach_w2", n_start, 2);
        repeat (3) tick();
        check_eq("abort_sh_done_drv", sh_done_i, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check_eq("abort_clr", fifo_clr_o, 1);
        check_eq("abort_busy", busy_o, 0);
        check_eq("abort_flag", aborted_o, 1);
        check_eq("abort_words", words_o, 1);
        check_eq("abort_rx_valid", rx_valid_o, 0);
        tick();
        check_eq("abort_clr_width", fifo_clr_o, 0);
        repeat (4) tick();
        check_eq("abort_no_done", n_done, 0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check_eq("idle_abort_clr", fifo_clr_o, 0);
        check_eq("aborted_sticky", aborted_o, 1);
        tx_q.delete(); exp_sh.delete(); exp_rx.delete(); sh_cnt = -1; rx_pend = 1'b0;
        tick();
        run_xfer(2, 1, 1, 0, 0, 1, 0, 1);

        // TX watermark: wm=1 while the level steps 3 -> 2 -> 1 in a stalled FETCH.
        tx_wm_i = 4'd1;
        prep(1, 1, 0, 1000, 0, 1, 0);
        start_xfer(1, 1, 0);
        tick();
        tx_elements_i = 4'd3;
        tick();
        check_eq("irq_tx_lvl3", irq_tx_o, 0);
        tx_elements_i = 4'd2;
        tick();
        check_eq("irq_tx_lvl2", irq_tx_o, 0);
        tx_elements_i = 4'd1;
        check_eq("irq_tx_same_cycle", irq_tx_o, 0);
        tick();
        check_eq("irq_tx_rise", irq_tx_o, 1);
        tx_hold_cnt = 0;
        wait_done(1, 0, 0);
        check_eq("irq_tx_idle", irq_tx_o, 0);
        tx_elements_i = 4'd4; tx_wm_i = 4'd0;

        // Randomised transfers
        for (int t = 0; t < 14; t++) begin
            run_xfer(int'($urandom_range(1, 6)), 1'($urandom), 1'($urandom), 0, 0, 1, 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
